conv2d_oen: RTL and testbench

CONV2D_OEN -- requirements
Module: CONV2D_OEN

---
 rtl/conv2d_oen_if.sv | 49 ++++
 rtl/conv2d_oen.sv | 211 +++++++++++++++++++++
 tb/tb_conv2d_oen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/conv2d_oen_if.sv
// conv2d_oen_if -- control/status bundle for the conv2d output-enable generator.
//
// Signals (master drives the inputs of conv2d_oen, slave is the generator):
//   CONV2D_OEN_Start          frame start, window memory primed
//   CONV2D_OEN_Advance        one candidate window position this cycle
//   CONV2D_OEN_Win_Cols       candidate positions per row
//   CONV2D_OEN_Of_Colums      output columns per row
//   CONV2D_OEN_Of_Rows        output rows per frame
//   CONV2D_OEN_Stride_X/_Y    horizontal / vertical stride
//   CONV2D_OEN_Wptclr         active-low write-pointer clear
//   CONV2D_OEN_Oen            output enable for the current window result
//   CONV2D_OEN_Col_Idx/_Row_Idx  output coordinates qualifying Oen
//   CONV2D_OEN_Flag_Out_Full  frame complete
//   CONV2D_OEN_In_Routine     frame in progress
interface conv2d_oen_if #(
    parameter int BITWIDTH_OF_COLUMS = 11,
    parameter int BITWIDTH_OF_ROWS   = 11,
    parameter int BITWIDTH_STRIDE    = 4
);
    logic                          CONV2D_OEN_Start;
    logic                          CONV2D_OEN_Advance;
    logic [BITWIDTH_OF_COLUMS-1:0] CONV2D_OEN_Win_Cols;
    logic [BITWIDTH_OF_COLUMS-1:0] CONV2D_OEN_Of_Colums;
    logic [BITWIDTH_OF_ROWS-1:0]   CONV2D_OEN_Of_Rows;
    logic [BITWIDTH_STRIDE-1:0]    CONV2D_OEN_Stride_X;
    logic [BITWIDTH_STRIDE-1:0]    CONV2D_OEN_Stride_Y;
    logic                          CONV2D_OEN_Wptclr;
    logic                          CONV2D_OEN_Oen;
    logic [BITWIDTH_OF_COLUMS-1:0] CONV2D_OEN_Col_Idx;
    logic [BITWIDTH_OF_ROWS-1:0]   CONV2D_OEN_Row_Idx;
    logic                          CONV2D_OEN_Flag_Out_Full;
    logic                          CONV2D_OEN_In_Routine;

    modport master (
        output CONV2D_OEN_Start, CONV2D_OEN_Advance, CONV2D_OEN_Win_Cols,
               CONV2D_OEN_Of_Colums, CONV2D_OEN_Of_Rows,
               CONV2D_OEN_Stride_X, CONV2D_OEN_Stride_Y,
        input  CONV2D_OEN_Wptclr, CONV2D_OEN_Oen, CONV2D_OEN_Col_Idx,
               CONV2D_OEN_Row_Idx, CONV2D_OEN_Flag_Out_Full, CONV2D_OEN_In_Routine
    );

    modport slave (
        input  CONV2D_OEN_Start, CONV2D_OEN_Advance, CONV2D_OEN_Win_Cols,
               CONV2D_OEN_Of_Colums, CONV2D_OEN_Of_Rows,
               CONV2D_OEN_Stride_X, CONV2D_OEN_Stride_Y,
        output CONV2D_OEN_Wptclr, CONV2D_OEN_Oen, CONV2D_OEN_Col_Idx,
               CONV2D_OEN_Row_Idx, CONV2D_OEN_Flag_Out_Full, CONV2D_OEN_In_Routine
    );
endinterface

// File: rtl/conv2d_oen.sv
// conv2d_oen -- decides which candidate window positions of a raster scan
// produce a convolution output, honouring column/row strides, and issues a
// registered output enable with the output coordinates.
//
// Ports:
//   CONV2D_OEN_Clk    clock, all state updates on the rising edge
//   CONV2D_OEN_Reset  synchronous active-high reset
//   bus               conv2d_oen_if slave modport (start/advance/config in,
//                     Wptclr/Oen/indices/status out)
module conv2d_oen #(
    parameter int BITWIDTH_OF_COLUMS = 11,
    parameter int BITWIDTH_OF_ROWS   = 11,
    parameter int BITWIDTH_STRIDE    = 4
) (
    input  logic         CONV2D_OEN_Clk,
    input  logic         CONV2D_OEN_Reset,
    conv2d_oen_if.slave  bus
);
    localparam int CW = BITWIDTH_OF_COLUMS;
    localparam int RW = BITWIDTH_OF_ROWS;
    localparam int SW = BITWIDTH_STRIDE;

    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COL_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] COL_MAX  = {CW{1'b1}};
    localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
    localparam logic [RW-1:0] ROW_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] ROW_MAX  = {RW{1'b1}};
    localparam logic [SW-1:0] STR_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0] STR_ONE  = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;

    // Configuration captured when Start is accepted
    logic [CW-1:0] win_cols_r;
    logic [CW-1:0] of_cols_r;
    logic [RW-1:0] of_rows_r;
    logic [SW-1:0] sx_r;
    logic [SW-1:0] sy_r;

    // Raster and phase counters
    logic [CW-1:0] x_r;
    logic [SW-1:0] xp_r;
    logic [SW-1:0] yp_r;
    logic [CW-1:0] col_cnt_r;
    logic [RW-1:0] row_cnt_r;

    // Registered outputs
    logic          wptclr_r;
    logic          oen_r;
    logic [CW-1:0] col_idx_r;
    logic [RW-1:0] row_idx_r;
    logic          full_r;
    logic          in_routine_r;

    logic          sel_s;
    logic          last_s;
    logic          row_end_s;
    logic          xp_wrap_s;
    logic          yp_wrap_s;
    logic          cfg_empty_s;

    // Decode output selection, frame end and row wrap for the current position
    always_comb begin
        sel_s       = 1'b0;
        last_s      = 1'b0;
        row_end_s   = 1'b0;
        xp_wrap_s   = 1'b0;
        yp_wrap_s   = 1'b0;
        cfg_empty_s = 1'b0;
        if ((bus.CONV2D_OEN_Of_Colums == COL_ZERO) || (bus.CONV2D_OEN_Of_Rows == ROW_ZERO)) begin
            cfg_empty_s = 1'b1;
        end else begin
            cfg_empty_s = 1'b0;
        end
        if ((state_r == ST_RUN) && bus.CONV2D_OEN_Advance) begin
            // Row-count limit also keeps a misconfigured frame from over-issuing
            sel_s = (xp_r == STR_ZERO) && (yp_r == STR_ZERO) &&
                    (col_cnt_r < of_cols_r) && (row_cnt_r < of_rows_r);
            last_s = sel_s && (row_cnt_r == (of_rows_r - ROW_ONE)) &&
                     (col_cnt_r == (of_cols_r - COL_ONE));
            // Widened compare so Win_Cols=0 cannot underflow into a huge row
            row_end_s = ({1'b0, x_r} + {1'b0, COL_ONE}) >= {1'b0, win_cols_r};
            xp_wrap_s = (xp_r + STR_ONE) >= sx_r;
            yp_wrap_s = (yp_r + STR_ONE) >= sy_r;
        end else begin
            sel_s     = 1'b0;
            last_s    = 1'b0;
            row_end_s = 1'b0;
            xp_wrap_s = 1'b0;
            yp_wrap_s = 1'b0;
        end
    end

    // Frame FSM, counters and registered outputs
    always_ff @(posedge CONV2D_OEN_Clk) begin
        if (CONV2D_OEN_Reset) begin
            state_r      <= ST_IDLE;
            win_cols_r   <= COL_ZERO;
            of_cols_r    <= COL_ZERO;
            of_rows_r    <= ROW_ZERO;
            sx_r         <= STR_ONE;
            sy_r         <= STR_ONE;
            x_r          <= COL_ZERO;
            xp_r         <= STR_ZERO;
            yp_r         <= STR_ZERO;
            col_cnt_r    <= COL_ZERO;
            row_cnt_r    <= ROW_ZERO;
            wptclr_r     <= 1'b1;
            oen_r        <= 1'b0;
            col_idx_r    <= COL_ZERO;
            row_idx_r    <= ROW_ZERO;
            full_r       <= 1'b0;
            in_routine_r <= 1'b0;
        end else begin
            oen_r    <= 1'b0;
            wptclr_r <= 1'b1;
            if (bus.CONV2D_OEN_Start) begin
                // Start is accepted in every state and restarts a running frame
                win_cols_r <= bus.CONV2D_OEN_Win_Cols;
                of_cols_r  <= bus.CONV2D_OEN_Of_Colums;
                of_rows_r  <= bus.CONV2D_OEN_Of_Rows;
                sx_r       <= (bus.CONV2D_OEN_Stride_X == STR_ZERO) ? STR_ONE : bus.CONV2D_OEN_Stride_X;
                sy_r       <= (bus.CONV2D_OEN_Stride_Y == STR_ZERO) ? STR_ONE : bus.CONV2D_OEN_Stride_Y;
                x_r        <= COL_ZERO;
                xp_r       <= STR_ZERO;
                yp_r       <= STR_ZERO;
                col_cnt_r  <= COL_ZERO;
                row_cnt_r  <= ROW_ZERO;
                col_idx_r  <= COL_ZERO;
                row_idx_r  <= ROW_ZERO;
                if (cfg_empty_s) begin
                    // Nothing to produce: frame is complete immediately
                    state_r      <= ST_DONE;
                    full_r       <= 1'b1;
                    in_routine_r <= 1'b0;
                end else begin
                    state_r      <= ST_RUN;
                    full_r       <= 1'b0;
                    in_routine_r <= 1'b1;
                    wptclr_r     <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    ST_RUN: begin
                        if (bus.CONV2D_OEN_Advance) begin
                            if (sel_s) begin
                                oen_r     <= 1'b1;
                                col_idx_r <= col_cnt_r;
                                row_idx_r <= row_cnt_r;
                                col_cnt_r <= (col_cnt_r == COL_MAX) ? COL_MAX : (col_cnt_r + COL_ONE);
                            end else begin
                                oen_r <= 1'b0;
                            end
                            if (last_s) begin
                                state_r      <= ST_DONE;
                                full_r       <= 1'b1;
                                in_routine_r <= 1'b0;
                            end else begin
                                state_r <= ST_RUN;
                            end
                            if (row_end_s) begin
                                x_r       <= COL_ZERO;
                                xp_r      <= STR_ZERO;
                                col_cnt_r <= COL_ZERO;
                                yp_r      <= yp_wrap_s ? STR_ZERO : (yp_r + STR_ONE);
                                // Only rows that produced outputs advance the output row
                                if ((yp_r == STR_ZERO) && ((col_cnt_r != COL_ZERO) || sel_s) &&
                                    (row_cnt_r != ROW_MAX)) begin
                                    row_cnt_r <= row_cnt_r + ROW_ONE;
                                end else begin
                                    row_cnt_r <= row_cnt_r;
                                end
                            end else begin
                                x_r  <= x_r + COL_ONE;
                                xp_r <= xp_wrap_s ? STR_ZERO : (xp_r + STR_ONE);
                            end
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        in_routine_r <= 1'b0;
                        full_r       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.CONV2D_OEN_Wptclr        = wptclr_r;
    assign bus.CONV2D_OEN_Oen           = oen_r;
    assign bus.CONV2D_OEN_Col_Idx       = col_idx_r;
    assign bus.CONV2D_OEN_Row_Idx       = row_idx_r;
    assign bus.CONV2D_OEN_Flag_Out_Full = full_r;
    assign bus.CONV2D_OEN_In_Routine    = in_routine_r;

endmodule

// File: tb/tb_conv2d_oen.sv
// tb_conv2d_oen -- directed self-checking bench for conv2d_oen.
module tb_conv2d_oen;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    conv2d_oen_if bus ();

    conv2d_oen dut (
        .CONV2D_OEN_Clk   (clk),
        .CONV2D_OEN_Reset (rst),
        .bus              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int win, input int oc, input int orows, input int sx, input int sy);
        bus.CONV2D_OEN_Win_Cols   = 11'(win);
        bus.CONV2D_OEN_Of_Colums  = 11'(oc);
        bus.CONV2D_OEN_Of_Rows    = 11'(orows);
        bus.CONV2D_OEN_Stride_X   = 4'(sx);
        bus.CONV2D_OEN_Stride_Y   = 4'(sy);
    endtask

    task automatic check_idle_state(input string tag);
        check_val({tag, "_oen"},    bus.CONV2D_OEN_Oen, 0);
        check_val({tag, "_wptclr"}, bus.CONV2D_OEN_Wptclr, 1);
        check_val({tag, "_full"},   bus.CONV2D_OEN_Flag_Out_Full, 0);
        check_val({tag, "_inrt"},   bus.CONV2D_OEN_In_Routine, 0);
        check_val({tag, "_col"},    bus.CONV2D_OEN_Col_Idx, 0);
        check_val({tag, "_row"},    bus.CONV2D_OEN_Row_Idx, 0);
    endtask

    // Start a frame, then advance through win*orows*sy positions and compare
    // every cycle against a position-based model of the selection rule.
    task automatic run_frame(input string tag, input int win, input int oc, input int orows,
                             input int sx, input int sy, input bit toggle, input int exp_total);
        int sxe, sye, x, y, nadv, total_adv, pulses, ncyc, nc, nr;
        bit adv, nxt_oen;
        sxe = (sx == 0) ? 1 : sx;
        sye = (sy == 0) ? 1 : sy;
        set_cfg(win, oc, orows, sx, sy);
        bus.CONV2D_OEN_Advance = 1'b0;
        bus.CONV2D_OEN_Start   = 1'b1;
        tick();
        bus.CONV2D_OEN_Start   = 1'b0;
        // Config changes after Start must not matter
        set_cfg(1, 1, 1, 3, 3);
        check_val({tag, "_wptclr_lo"}, bus.CONV2D_OEN_Wptclr, 0);
        check_val({tag, "_inrt"},      bus.CONV2D_OEN_In_Routine, 1);
        check_val({tag, "_full0"},     bus.CONV2D_OEN_Flag_Out_Full, 0);
        check_val({tag, "_col0"},      bus.CONV2D_OEN_Col_Idx, 0);
        check_val({tag, "_row0"},      bus.CONV2D_OEN_Row_Idx, 0);
        x = 0; y = 0; nadv = 0; pulses = 0; nc = 0; nr = 0;
        total_adv = win * orows * sye;
        ncyc = (toggle ? 2 : 1) * total_adv + 2;
        for (int c = 0; c < ncyc; c++) begin
            adv = toggle ? ((c % 2) == 0) : 1'b1;
            if (nadv >= total_adv) adv = 1'b0;
            bus.CONV2D_OEN_Advance = adv;
            nxt_oen = 1'b0;
            if (adv) begin
                if ((x % sxe == 0) && (y % sye == 0) && (x / sxe < oc) && (y / sye < orows)) begin
                    nxt_oen = 1'b1;
                    nc = x / sxe;
                    nr = y / sye;
                end
                x++;
                if (x >= win) begin
                    x = 0;
                    y++;
                end
                nadv++;
            end
            tick();
            if (c == 0) check_val({tag, "_wptclr_hi"}, bus.CONV2D_OEN_Wptclr, 1);
            check_val({tag, "_oen"}, bus.CONV2D_OEN_Oen, nxt_oen);
            if (nxt_oen) begin
                pulses++;
                check_val({tag, "_col"},  bus.CONV2D_OEN_Col_Idx, nc);
                check_val({tag, "_row"},  bus.CONV2D_OEN_Row_Idx, nr);
                check_val({tag, "_full"}, bus.CONV2D_OEN_Flag_Out_Full,
                          ((nc == oc - 1) && (nr == orows - 1)) ? 1 : 0);
            end
        end
        bus.CONV2D_OEN_Advance = 1'b0;
        check_val({tag, "_pulses"},   pulses, exp_total);
        check_val({tag, "_full_end"}, bus.CONV2D_OEN_Flag_Out_Full, 1);
        check_val({tag, "_inrt_end"}, bus.CONV2D_OEN_In_Routine, 0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.CONV2D_OEN_Start   = 1'b0;
        bus.CONV2D_OEN_Advance = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        tick();
        tick();
        check_idle_state("reset");
        rst = 1'b0;

        // Advance in IDLE is ignored
        bus.CONV2D_OEN_Advance = 1'b1;
        tick();
        tick();
        bus.CONV2D_OEN_Advance = 1'b0;
        check_idle_state("idle_adv");

        // 5x3 outputs, unit stride, Advance held high
        run_frame("full_rate", 5, 5, 3, 1, 1, 1'b0, 15);

        // Advance in DONE is ignored, Full holds
        bus.CONV2D_OEN_Advance = 1'b1;
        tick();
        tick();
        bus.CONV2D_OEN_Advance = 1'b0;
        check_val("done_oen",  bus.CONV2D_OEN_Oen, 0);
        check_val("done_full", bus.CONV2D_OEN_Flag_Out_Full, 1);

        // Stride 2 in both directions
        run_frame("stride2", 8, 4, 2, 2, 2, 1'b0, 8);

        // Same as full_rate with Advance toggling
        run_frame("toggle", 5, 5, 3, 1, 1, 1'b1, 15);

        // Partial frame, then restart while running
        set_cfg(5, 5, 3, 1, 1);
        bus.CONV2D_OEN_Start = 1'b1;
        tick();
        bus.CONV2D_OEN_Start   = 1'b0;
        bus.CONV2D_OEN_Advance = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.CONV2D_OEN_Advance = 1'b0;
        run_frame("restart", 8, 4, 2, 2, 2, 1'b0, 8);

        // Reset mid row 2, with Start and Advance also high: reset wins
        set_cfg(5, 5, 3, 1, 1);
        bus.CONV2D_OEN_Start = 1'b1;
        tick();
        bus.CONV2D_OEN_Start   = 1'b0;
        bus.CONV2D_OEN_Advance = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check_val("mid_row2", bus.CONV2D_OEN_Row_Idx, 2);
        rst = 1'b1;
        bus.CONV2D_OEN_Start = 1'b1;
        tick();
        rst = 1'b0;
        bus.CONV2D_OEN_Start   = 1'b0;
        bus.CONV2D_OEN_Advance = 1'b0;
        check_idle_state("mid_reset");
        run_frame("after_reset", 5, 5, 3, 1, 1, 1'b0, 15);

        // Of_Rows=0: straight to DONE, Full set, no Wptclr pulse, no Oen
        set_cfg(5, 5, 0, 1, 1);
        bus.CONV2D_OEN_Start = 1'b1;
        tick();
        bus.CONV2D_OEN_Start   = 1'b0;
        check_val("rows0_full",   bus.CONV2D_OEN_Flag_Out_Full, 1);
        check_val("rows0_inrt",   bus.CONV2D_OEN_In_Routine, 0);
        check_val("rows0_wptclr", bus.CONV2D_OEN_Wptclr, 1);
        bus.CONV2D_OEN_Advance = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rows0_oen", bus.CONV2D_OEN_Oen, 0);
        end
        bus.CONV2D_OEN_Advance = 1'b0;

        // Stride_X=0 behaves as stride 1
        run_frame("sx0", 5, 5, 3, 0, 1, 1'b0, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
